fir_alu_sequencer: RTL and testbench

- Sequencer for the FIR core that drives the shared `alu` on its operand/select interface.
- Accepts input samples and loadable coefficients, and holds a circular sample delay line plus a coefficient file.
- For each sample it issues TAPS multiply operations to the ALU, accumulates the returned products, and emits one saturated 32-bit filter output per sample.

---
 rtl/fir_pkg.sv | 36 +++
 rtl/fir_delay_line.sv | 47 ++++
 rtl/fir_alu_sequencer.sv | 176 +++++++++++++++++
 tb/tb_fir_alu_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// ============================================================================
// fir_pkg : shared constants, state encoding and saturation helper for the FIR
// Revision: 1.0
// ============================================================================
`default_nettype none

package fir_pkg;

  localparam int DW_DEF = 16;
  localparam int RW_DEF = 32;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_MUL = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACC   = 3'd3,
    ST_OUT   = 3'd4
  } fir_state_e;

  // Clamp v into the signed range of a w-bit value (w <= 63).
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_delay_line.sv
// ============================================================================
// fir_delay_line : circular sample buffer, newest sample at wp, read by offset
// Revision: 1.0
// ============================================================================
`default_nettype none

module fir_delay_line #(
  parameter int TAPS = 64,
  parameter int DW   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DW-1:0]           wr_data,
  input  logic [$clog2(TAPS)-1:0] rd_offset,
  output logic [DW-1:0]           rd_data
);

  localparam int PW = $clog2(TAPS);

  logic [DW-1:0] line_q [TAPS];
  logic [PW-1:0] wp_q;
  logic [PW-1:0] wp_d;
  logic [PW-1:0] rd_idx;

  always_comb begin
    wp_d = wp_q;
    if (wr_en) wp_d = wp_q + PW'(1);
  end

  // Offset k reaches back k samples; the power-of-two pointer wraps for free.
  assign rd_idx  = wp_q - rd_offset;
  assign rd_data = line_q[rd_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q <= '0;
      for (int i = 0; i < TAPS; i++) line_q[i] <= '0;
    end else begin
      wp_q <= wp_d;
      if (wr_en) line_q[wp_d] <= wr_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fir_alu_sequencer.sv
// ============================================================================
// fir_alu_sequencer : issues TAPS multiplies per sample to the shared ALU,
// accumulates the products and emits one saturated output per sample
// Revision: 1.0
// ============================================================================
`default_nettype none

module fir_alu_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS    = 64,
  parameter int DW      = DW_DEF,
  parameter int RW      = RW_DEF,
  parameter int ALU_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DW-1:0]           x_data,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [DW-1:0]           coef_data,
  output logic                    coef_err,
  output logic [DW-1:0]           alu_a,
  output logic [DW-1:0]           alu_b,
  output logic [1:0]              alu_select,
  input  logic [RW-1:0]           alu_result,
  output logic [RW-1:0]           y_data,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic                    busy
);

  localparam int KW = $clog2(TAPS);
  localparam int AW = RW + KW;
  localparam int CW = $clog2(ALU_LAT + 1);

  fir_state_e state_q, state_d;

  logic [KW-1:0]        k_q, k_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [DW-1:0]        alu_a_q, alu_a_d;
  logic [DW-1:0]        alu_b_q, alu_b_d;
  logic [1:0]           alu_select_q, alu_select_d;
  logic [RW-1:0]        y_data_q, y_data_d;
  logic                 y_valid_q, y_valid_d;
  logic                 coef_err_q, coef_err_d;

  logic [DW-1:0]        coef_q [TAPS];
  logic                 idle;
  logic                 x_accept;
  logic                 coef_wr;
  logic [DW-1:0]        tap_sample;
  logic signed [63:0]   acc_ext;

  assign idle     = (state_q == ST_IDLE);
  assign x_accept = x_valid && idle;
  assign coef_wr  = coef_we && idle;
  assign acc_ext  = {{(64 - AW){acc_q[AW-1]}}, acc_q};

  fir_delay_line #(
    .TAPS (TAPS),
    .DW   (DW)
  ) u_line (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (x_accept),
    .wr_data   (x_data),
    .rd_offset (k_q),
    .rd_data   (tap_sample)
  );

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_select_d = alu_select_q;
    y_data_d     = y_data_q;
    y_valid_d    = y_valid_q;
    coef_err_d   = coef_we && !idle;

    case (state_q)
      ST_IDLE: begin
        if (x_valid) begin
          acc_d   = '0;
          k_d     = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        alu_a_d      = tap_sample;
        alu_b_d      = coef_q[k_q];
        alu_select_d = ALU_OP_MUL;
        cnt_d        = CW'(ALU_LAT);
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_ACC;
      end
      ST_ACC: begin
        // The accumulator carries log2(TAPS) guard bits, so it cannot wrap.
        acc_d = acc_q + {{KW{alu_result[RW-1]}}, alu_result};
        if (k_q == KW'(TAPS - 1)) begin
          alu_select_d = ALU_OP_ADD;
          state_d      = ST_OUT;
        end else begin
          k_d     = k_q + KW'(1);
          state_d = ST_ISSUE;
        end
      end
      ST_OUT: begin
        if (!y_valid_q) begin
          y_valid_d = 1'b1;
          y_data_d  = RW'(saturate(acc_ext, RW));
        end else if (y_ready) begin
          y_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_select_q <= ALU_OP_ADD;
      y_data_q     <= '0;
      y_valid_q    <= 1'b0;
      coef_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_select_q <= alu_select_d;
      y_data_q     <= y_data_d;
      y_valid_q    <= y_valid_d;
      coef_err_q   <= coef_err_d;
    end
  end

  // A write issued together with a sample accept is seen by that sample's taps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
    end else if (coef_wr) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  assign x_ready    = rst && idle;
  assign busy       = !idle;
  assign coef_err   = coef_err_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_select = alu_select_q;
  assign y_data     = y_data_q;
  assign y_valid    = y_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_alu_sequencer.sv
// ============================================================================
// tb_fir_alu_sequencer : directed scoreboard bench with a behavioural ALU
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fir_alu_sequencer;

  localparam int TAPS    = 64;
  localparam int DW      = 16;
  localparam int RW      = 32;
  localparam int ALU_LAT = 2;
  localparam int KW      = 6;
  localparam int LAT     = TAPS * (ALU_LAT + 2) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] x_data;
  logic          x_valid;
  logic          x_ready;
  logic          coef_we;
  logic [KW-1:0] coef_addr;
  logic [DW-1:0] coef_data;
  logic          coef_err;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [1:0]    alu_select;
  logic [RW-1:0] alu_result;
  logic [RW-1:0] y_data;
  logic          y_valid;
  logic          y_ready;
  logic          busy;

  always #5 clk = ~clk;

  fir_alu_sequencer #(
    .TAPS    (TAPS),
    .DW      (DW),
    .RW      (RW),
    .ALU_LAT (ALU_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .x_data     (x_data),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .coef_err   (coef_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_select (alu_select),
    .alu_result (alu_result),
    .y_data     (y_data),
    .y_valid    (y_valid),
    .y_ready    (y_ready),
    .busy       (busy)
  );

  // Shared ALU model: result valid ALU_LAT cycles after operands settle.
  logic signed [RW-1:0] alu_p0, alu_p1;
  always @(posedge clk) begin
    if (alu_select == 2'b01) alu_p0 <= $signed(alu_a) * $signed(alu_b);
    else                     alu_p0 <= $signed(alu_a) + $signed(alu_b);
    alu_p1 <= alu_p0;
  end
  assign alu_result = alu_p1;

  int     n_cmp = 0;
  int     n_err = 0;
  longint sb[$];
  int     tb_h[TAPS];
  int     hist[$];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint model_y();
    longint s;
    s = 0;
    for (int k = 0; k < hist.size(); k++) s += longint'(tb_h[k]) * longint'(hist[k]);
    if (s > 64'sd2147483647)  s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
    return s;
  endfunction

  task automatic do_reset();
    rst       = 1'b0;
    x_valid   = 1'b0;
    x_data    = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    y_ready   = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < TAPS; i++) tb_h[i] = 0;
    hist.delete();
    sb.delete();
  endtask

  // mode 0: h[k]=k+1, mode 1: h[k]=1, mode 2: h[k]=32767
  task automatic load_coefs(input int mode);
    int v;
    for (int k = 0; k < TAPS; k++) begin
      v = (mode == 0) ? k + 1 : (mode == 1) ? 1 : 32767;
      coef_we   = 1'b1;
      coef_addr = KW'(k);
      coef_data = DW'(v);
      tb_h[k]   = v;
      tick();
    end
    coef_we = 1'b0;
    chk("coef_err_legal", longint'(coef_err), 0);
  endtask

  task automatic send_sample(input int x, input int hold, input int bad_at,
                             input bit cw, input int ca, input int cd);
    int     n;
    longint held;
    chk("x_ready_idle", longint'(x_ready), 1);
    x_data  = DW'(x);
    x_valid = 1'b1;
    if (cw) begin
      coef_we   = 1'b1;
      coef_addr = KW'(ca);
      coef_data = DW'(cd);
      tb_h[ca]  = cd;
    end
    hist.push_front(x);
    if (hist.size() > TAPS) void'(hist.pop_back());
    sb.push_back(model_y());
    tick();
    x_valid = 1'b0;
    coef_we = 1'b0;
    n = 0;
    while (!y_valid && n < LAT + 50) begin
      if (n == bad_at) begin
        coef_we   = 1'b1;
        coef_addr = 6'd5;
        coef_data = 16'd7;
      end
      tick();
      n++;
      if (bad_at >= 0 && n == bad_at + 1) begin
        coef_we = 1'b0;
        chk("coef_err_pulse", longint'(coef_err), 1);
      end
      if (bad_at >= 0 && n == bad_at + 2) chk("coef_err_one_cycle", longint'(coef_err), 0);
    end
    chk("latency", longint'(n), longint'(LAT));
    held = longint'($signed(y_data));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("bp_y_data", longint'($signed(y_data)), held);
      chk("bp_x_ready", longint'(x_ready), 0);
    end
    chk("y_data", longint'($signed(y_data)), sb.pop_front());
    y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
    chk("y_valid_drop", longint'(y_valid), 0);
    chk("x_ready_back", longint'(x_ready), 1);
  endtask

  initial begin
    rst       = 1'b0;
    x_valid   = 1'b0;
    x_data    = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    y_ready   = 1'b0;
    #2;
    chk("rst_alu_a", longint'(alu_a), 0);
    chk("rst_alu_b", longint'(alu_b), 0);
    chk("rst_alu_select", longint'(alu_select), 0);
    chk("rst_y_data", longint'(y_data), 0);
    chk("rst_y_valid", longint'(y_valid), 0);
    chk("rst_coef_err", longint'(coef_err), 0);
    chk("rst_busy", longint'(busy), 0);
    do_reset();
    chk("rst_x_ready", longint'(x_ready), 1);

    // Impulse response equals the coefficient sequence.
    load_coefs(0);
    send_sample(1, 0, -1, 1'b0, 0, 0);
    for (int i = 1; i < TAPS; i++) send_sample(0, 0, -1, 1'b0, 0, 0);

    // DC ramp through delay-line wrap; last sample held under backpressure.
    do_reset();
    load_coefs(1);
    for (int i = 0; i < 69; i++) send_sample(100, 0, -1, 1'b0, 0, 0);
    send_sample(100, 20, -1, 1'b0, 0, 0);

    // Rejected write while busy, then write concurrent with an accept.
    send_sample(100, 0, 10, 1'b0, 0, 0);
    send_sample(100, 0, -1, 1'b1, 0, 3);

    // Positive and negative saturation.
    do_reset();
    load_coefs(2);
    for (int i = 0; i < 3; i++) send_sample(32767, 0, -1, 1'b0, 0, 0);
    do_reset();
    load_coefs(2);
    for (int i = 0; i < 3; i++) send_sample(-32768, 0, -1, 1'b0, 0, 0);

    // Reset in the middle of a computation.
    x_data  = 16'd1;
    x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    repeat (30 * (ALU_LAT + 2)) tick();
    chk("mid_busy", longint'(busy), 1);
    rst = 1'b0;
    #1;
    chk("mid_alu_a", longint'(alu_a), 0);
    chk("mid_alu_b", longint'(alu_b), 0);
    chk("mid_alu_select", longint'(alu_select), 0);
    chk("mid_y_data", longint'(y_data), 0);
    chk("mid_y_valid", longint'(y_valid), 0);
    chk("mid_busy_clr", longint'(busy), 0);
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < TAPS; i++) tb_h[i] = 0;
    hist.delete();
    sb.delete();
    send_sample(1, 0, -1, 1'b0, 0, 0);
    load_coefs(0);
    send_sample(0, 0, -1, 1'b0, 0, 0);
    send_sample(0, 0, -1, 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
